// File: rtl/sample_tx_stream.sv
// sample_tx_stream: streams 16-bit samples from a synchronous-read memory over
// an 8N1 UART line, low byte first. One fetch/wait/latch sequence per sample,
// then two back-to-back byte frames.
// Optional build macro TX_CHECKSUM_EN: appends one frame holding the XOR of
// every data byte sent in the stream (suppressed by ABORT).
module sample_tx_stream #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        ABORT,
    input  logic [13:0] sample_count,
    output logic        rd_en,
    output logic [13:0] rd_address,
    input  logic [15:0] rd_data,
    output logic        UART_TXD,
    output logic        busy,
    output logic        done,
    output logic [7:0]  LEDG
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StLatch,
        StSendLo,
        StSendHi,
`ifdef TX_CHECKSUM_EN
        StSendCk,
`endif
        StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [13:0]        addr_q, addr_d;
    logic [13:0]        count_q, count_d;
    logic [15:0]        hold_q, hold_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [3:0]         bit_q, bit_d;
    logic               tx_q, tx_d;
    logic [7:0]         ledg_q, ledg_d;
    logic               abort_q, abort_d;
`ifdef TX_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic       sending;
    logic       baud_end;
    logic       frame_end;
    logic       abort_pend;
    logic       last_sample;
    logic [7:0] cur_byte;

    // Frame bookkeeping shared by every sending state.
    always_comb begin
        sending = (state_q == StSendLo) || (state_q == StSendHi);
`ifdef TX_CHECKSUM_EN
        if (state_q == StSendCk) sending = 1'b1;
`endif
        baud_end    = (baud_q == BaudLast);
        frame_end   = baud_end && (bit_q == 4'd9);
        // Same-cycle ABORT counts, so a request on the final stop cycle still stops the stream.
        abort_pend  = abort_q | ABORT;
        last_sample = ((addr_q + 14'd1) == count_q);
    end

    // Byte currently being serialised.
    always_comb begin
        cur_byte = hold_q[7:0];
        if (state_q == StSendHi) cur_byte = hold_q[15:8];
`ifdef TX_CHECKSUM_EN
        if (state_q == StSendCk) cur_byte = csum_q;
`endif
    end

    // Next-state logic for the sequencer, serialiser and status registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        hold_d  = hold_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        ledg_d  = ledg_q;
        abort_d = (state_q == StIdle) ? 1'b0 : abort_pend;
`ifdef TX_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        // Bit timing: bit 0 is start, 1..8 data LSB first, 9 stop.
        if (sending) begin
            if (baud_end) begin
                baud_d = '0;
                if (!frame_end) begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte[bit_q[2:0]];
                end
            end else begin
                baud_d = baud_q + BaudW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    count_d = sample_count;
                    addr_d  = '0;
`ifdef TX_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (sample_count == 14'd0) ? StFinish : StFetch;
                end
            end
            StFetch: begin
                state_d = abort_pend ? StIdle : StWait;
            end
            StWait: begin
                hold_d = rd_data;
`ifdef TX_CHECKSUM_EN
                csum_d = csum_q ^ rd_data[7:0] ^ rd_data[15:8];
`endif
                state_d = abort_pend ? StIdle : StLatch;
            end
            StLatch: begin
                if (abort_pend) begin
                    state_d = StIdle;
                end else begin
                    state_d = StSendLo;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    baud_d  = '0;
                end
            end
            StSendLo: begin
                if (frame_end) begin
                    ledg_d = hold_q[7:0];
                    if (abort_pend) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StSendHi;
                        tx_d    = 1'b0;
                        bit_d   = '0;
                    end
                end
            end
            StSendHi: begin
                if (frame_end) begin
                    ledg_d = hold_q[15:8];
                    addr_d = addr_q + 14'd1;
                    if (abort_pend) begin
                        state_d = StIdle;
                    end else if (last_sample) begin
`ifdef TX_CHECKSUM_EN
                        state_d = StSendCk;
                        tx_d    = 1'b0;
                        bit_d   = '0;
`else
                        state_d = StFinish;
`endif
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
`ifdef TX_CHECKSUM_EN
            StSendCk: begin
                if (frame_end) begin
                    ledg_d  = csum_q;
                    state_d = abort_pend ? StIdle : StFinish;
                end
            end
`endif
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; reset abandons any frame in flight and idles the line.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ledg_q  <= '0;
            abort_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ledg_q  <= ledg_d;
            abort_q <= abort_d;
`ifdef TX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Outputs decoded from registered state; busy is already low while done pulses.
    always_comb begin
        rd_en      = (state_q == StFetch);
        rd_address = addr_q;
        busy       = (state_q != StIdle) && (state_q != StFinish);
        done       = (state_q == StFinish);
        UART_TXD   = tx_q;
        LEDG       = ledg_q;
    end

endmodule

// File: tb/tb_sample_tx_stream.sv
// tb_sample_tx_stream: drives randomised and directed streams into
// sample_tx_stream (CLKS_PER_BIT=4) and compares the decoded UART byte stream,
// frame spacing, read addresses and status outputs against a byte-list model.
module tb_sample_tx_stream;

    localparam int unsigned Cpb = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [13:0] cnt_in = '0;
    logic        rd_en;
    logic [13:0] rd_address;
    logic [15:0] rd_data = '0;
    logic        txd;
    logic        busy;
    logic        done;
    logic [7:0]  ledg;

    sample_tx_stream #(.CLKS_PER_BIT(Cpb)) dut (
        .CLOCK_50     (clk),
        .RESET_N      (rst_n),
        .START        (start),
        .ABORT        (abort),
        .sample_count (cnt_in),
        .rd_en        (rd_en),
        .rd_address   (rd_address),
        .rd_data      (rd_data),
        .UART_TXD     (txd),
        .busy         (busy),
        .done         (done),
        .LEDG         (ledg)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears the cycle after rd_en and holds.
    logic [15:0] mem [16384];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: decodes 8N1 frames by sampling mid-bit on the falling clock edge.
    logic [7:0] rx_q [$];
    int         st_q [$];
    int         rdq  [$];
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    int         low_cnt   = 0;
    int         frame_err = 0;
    bit         mon_on    = 0;
    int         mon_cnt   = 0;
    logic [7:0] mon_byte  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_on = 0;
        end else begin
            if (rd_en) rdq.push_back(int'(rd_address));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) frame_err++;
            end
            if (!txd) low_cnt++;
            if (!mon_on) begin
                if (!txd) begin
                    mon_on  = 1;
                    mon_cnt = 0;
                    st_q.push_back(cyc);
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == Cpb / 2 && txd) frame_err++;
                if (mon_cnt >= Cpb + Cpb / 2 && mon_cnt < 9 * Cpb && (mon_cnt % Cpb) == Cpb / 2)
                    mon_byte[(mon_cnt - Cpb - Cpb / 2) / Cpb] = txd;
                if (mon_cnt == 9 * Cpb + Cpb / 2) begin
                    if (!txd) frame_err++;
                    rx_q.push_back(mon_byte);
                end
                if (mon_cnt == 10 * Cpb - 1) mon_on = 0;
            end
        end
    end

    task automatic clear_log();
        rx_q.delete();
        st_q.delete();
        rdq.delete();
        done_cnt  = 0;
        low_cnt   = 0;
        frame_err = 0;
    endtask

    // Reference: the byte list a complete stream of n samples must produce.
    task automatic build_model(input int n, output logic [7:0] exp_q [$]);
        logic [7:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i][7:0]);
            exp_q.push_back(mem[i][15:8]);
            x = x ^ mem[i][7:0] ^ mem[i][15:8];
        end
`ifdef TX_CHECKSUM_EN
        if (n > 0) exp_q.push_back(x);
`endif
    endtask

    int start_cyc = 0;

    task automatic pulse_start(input int n);
        @(negedge clk);
        #1;
        cnt_in    = 14'(n);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Compares the first nb model bytes, their spacing, reads and status.
    task automatic check_stream(input string tag, input int n, input int nb, input int naddr,
                                input int exp_done);
        logic [7:0] exp_q [$];
        build_model(n, exp_q);
        check_eq({tag, "_nbytes"}, rx_q.size(), nb);
        for (int i = 0; i < nb && i < rx_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        if (st_q.size() > 0) check_eq({tag, "_first_start"}, st_q[0] - start_cyc, 4);
        for (int i = 1; i < st_q.size(); i++)
            check_eq($sformatf("%s_gap%0d", tag, i), st_q[i] - st_q[i-1],
                     ((i % 2) == 1 || i >= 2 * n) ? 10 * Cpb : 10 * Cpb + 3);
        check_eq({tag, "_nreads"}, rdq.size(), naddr);
        for (int i = 0; i < naddr && i < rdq.size(); i++)
            check_eq($sformatf("%s_addr%0d", tag, i), rdq[i], i);
        check_eq({tag, "_done"}, done_cnt, exp_done);
        if (nb > 0) check_eq({tag, "_ledg"}, ledg, exp_q[nb-1]);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_txd_end"}, txd, 1);
        check_eq({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic wait_until_starts(input int k);
        for (int i = 0; i < 2000 && st_q.size() < k; i++) @(negedge clk);
        check_eq($sformatf("reach_frame%0d", k), st_q.size() >= k, 1);
    endtask

    int n;
    int nfull;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;

        // Reset values while held in reset.
        #12;
        check_eq("rst_txd", txd, 1);
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_addr", rd_address, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ledg", ledg, 0);

        // Single sample, START on the very first edge after reset release.
        mem[0] = 16'hA55A;
        @(negedge clk);
        #1;
        clear_log();
        rst_n     = 1'b1;
        cnt_in    = 14'd1;
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (120) @(negedge clk);
        check_stream("one", 1, nfull_of(1), 1, 1);
        check_eq("one_ledg_a5", ledg, `ifdef TX_CHECKSUM_EN 8'hFF `else 8'hA5 `endif);

        // Three samples with fixed contents.
        mem[0] = 16'h0102;
        mem[1] = 16'h0304;
        mem[2] = 16'h0506;
        clear_log();
        pulse_start(3);
        repeat (300) @(negedge clk);
        check_stream("three", 3, nfull_of(3), 3, 1);

        // Zero-length request.
        clear_log();
        pulse_start(0);
        repeat (20) @(negedge clk);
        check_eq("zero_done", done_cnt, 1);
        check_eq("zero_done_lat", (done_cyc - start_cyc) <= 2, 1);
        check_eq("zero_rd", rdq.size(), 0);
        check_eq("zero_txd_low", low_cnt, 0);

        // Randomised streams.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
            n = $urandom_range(1, 4);
            clear_log();
            pulse_start(n);
            repeat (n * 90 + 60) @(negedge clk);
            check_stream($sformatf("rnd%0d", t), n, nfull_of(n), n, 1);
        end

        // ABORT during sample 1 high byte: that frame finishes, nothing after.
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        clear_log();
        pulse_start(4);
        wait_until_starts(4);
        repeat (10) @(negedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        #1;
        abort = 1'b0;
        repeat (400) @(negedge clk);
        check_stream("abort", 4, 4, 2, 0);

        // Reset during sample 0 low byte data bit 3, then a clean restart.
        clear_log();
        pulse_start(2);
        wait_until_starts(1);
        repeat (4 * Cpb + 1) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_txd", txd, 1);
        check_eq("mid_rst_rd_en", rd_en, 0);
        check_eq("mid_rst_addr", rd_address, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_ledg", ledg, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_txd", txd, 1);
        mem[0] = 16'h1234;
        clear_log();
        pulse_start(1);
        repeat (150) @(negedge clk);
        check_stream("restart", 1, nfull_of(1), 1, 1);

        // START while busy is ignored.
        for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
        clear_log();
        pulse_start(2);
        wait_until_starts(1);
        #1;
        cnt_in = 14'd7;
        start  = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (400) @(negedge clk);
        check_stream("restart_ign", 2, nfull_of(2), 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic int nfull_of(input int k);
`ifdef TX_CHECKSUM_EN
        return (k > 0) ? 2 * k + 1 : 0;
`else
        return 2 * k;
`endif
    endfunction

endmodule
